red_pitaya_asg_burst_ch: RTL

//  Parametrised single-clock arbitrary-signal-generator channel: table RAM, fixed-point read pointer,

---
 rtl/red_pitaya_asg_pkg.sv | 16 +
 rtl/red_pitaya_asg_trig_edge.sv | 42 ++++
 rtl/red_pitaya_asg_burst_ch.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_asg_pkg.sv
// Shared constants for the ASG burst channel: FSM state codes, trigger source codes
// and sample pipeline latencies.
package red_pitaya_asg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DLY  = 2'd2;

    localparam logic [2:0] TRIG_SW       = 3'd1;
    localparam logic [2:0] TRIG_EXT_RISE = 3'd2;
    localparam logic [2:0] TRIG_EXT_FALL = 3'd3;

    localparam int LAT_NEAREST = 5;
    localparam int LAT_INTERP  = 7;

endpackage

// File: rtl/red_pitaya_asg_trig_edge.sv
// External trigger conditioning: two-flop synchroniser, edge detection and a hold-off
// window of DEB_CYC cycles during which further edges are ignored.
module red_pitaya_asg_trig_edge #(
    parameter int DEB_CYC = 125000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;

    // sync[1:0] is the synchroniser chain, sync[2] the previous synchronised level
    logic [2:0]    sync;
    logic [CW-1:0] hold;
    logic          edge_seen;

    assign edge_seen = sync[1] ^ sync[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            hold   <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            sync   <= {sync[1:0], trig_i};
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (hold != '0) begin
                hold <= hold - 1'b1;
            end else if (edge_seen) begin
                rise_o <= sync[1];
                fall_o <= ~sync[1];
                hold   <= CW'(DEB_CYC);
            end
        end
    end

endmodule

// File: rtl/red_pitaya_asg_burst_ch.sv
// One ASG DAC channel: table RAM, fixed-point read pointer, burst/repeat FSM and
// gain/offset/saturation. Define ASG_CH_LINEAR_INTERP_EN for linear interpolation.
module red_pitaya_asg_burst_ch
    import red_pitaya_asg_pkg::*;
#(
    parameter int DW       = 14,
    parameter int RSZ      = 14,
    parameter int FRW      = 16,
    parameter int TICK_DIV = 250,
    parameter int DEB_CYC  = 125000
) (
    input  logic               dac_clk_i,
    input  logic               dac_rst_i,
    input  logic               trig_sw_i,
    input  logic               trig_ext_i,
    input  logic [2:0]         trig_src_i,
    input  logic               buf_we_i,
    input  logic [RSZ-1:0]     buf_addr_i,
    input  logic [DW-1:0]      buf_wdata_i,
    output logic [DW-1:0]      buf_rdata_o,
    output logic [RSZ-1:0]     buf_rpnt_o,
    input  logic [RSZ+FRW-1:0] set_size_i,
    input  logic [RSZ+FRW-1:0] set_step_i,
    input  logic [RSZ+FRW-1:0] set_ofs_i,
    input  logic               set_rst_i,
    input  logic               set_wrap_i,
    input  logic [DW-1:0]      set_amp_i,
    input  logic [DW-1:0]      set_dc_i,
    input  logic               set_zero_i,
    input  logic [15:0]        set_ncyc_i,
    input  logic [15:0]        set_rnum_i,
    input  logic [31:0]        set_rdly_i,
    output logic               trig_done_o,
    output logic               burst_done_o,
    output logic [1:0]         state_o,
    output logic [DW-1:0]      dac_o
);

    localparam int PW = RSZ + FRW;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0] table_mem [0:(2**RSZ)-1];

    always_ff @(posedge dac_clk_i) begin
        if (buf_we_i)
            table_mem[buf_addr_i] <= buf_wdata_i;
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i)
            buf_rdata_o <= '0;
        else
            buf_rdata_o <= table_mem[buf_addr_i];
    end

    logic ext_rise, ext_fall, trig;

    red_pitaya_asg_trig_edge #(.DEB_CYC(DEB_CYC)) u_trig_edge (
        .clk    (dac_clk_i),
        .rst    (dac_rst_i),
        .trig_i (trig_ext_i),
        .rise_o (ext_rise),
        .fall_o (ext_fall)
    );

    always_comb begin
        trig = 1'b0;
        case (trig_src_i)
            TRIG_SW:       trig = trig_sw_i;
            TRIG_EXT_RISE: trig = ext_rise;
            TRIG_EXT_FALL: trig = ext_fall;
            default:       trig = 1'b0;
        endcase
    end

    logic [1:0]    state;
    logic [PW-1:0] pnt;
    logic [PW:0]   pnt_next, pnt_wrap;
    logic          period_end, last_period, last_burst;
    logic [15:0]   cyc_cnt, rep_cnt, rnum_eff;
    logic [31:0]   dly_cnt;
    logic [TW-1:0] tick_cnt;

    // one extra pointer bit so the overflow past set_size_i is visible
    assign pnt_next    = {1'b0, pnt} + {1'b0, set_step_i};
    assign pnt_wrap    = pnt_next - {1'b0, set_size_i} - {{PW{1'b0}}, 1'b1};
    assign period_end  = pnt_next > {1'b0, set_size_i};
    assign rnum_eff    = (set_rnum_i == 16'd0) ? 16'd1 : set_rnum_i;
    assign last_period = period_end && (set_ncyc_i != 16'd0) && (cyc_cnt + 16'd1 == set_ncyc_i);
    assign last_burst  = (rep_cnt + 16'd1) >= rnum_eff;
    assign state_o     = state;

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state        <= ST_IDLE;
            pnt          <= '0;
            cyc_cnt      <= '0;
            rep_cnt      <= '0;
            dly_cnt      <= '0;
            tick_cnt     <= '0;
            trig_done_o  <= 1'b0;
            burst_done_o <= 1'b0;
        end else begin
            trig_done_o  <= 1'b0;
            burst_done_o <= 1'b0;
            if (set_rst_i) begin
                state    <= ST_IDLE;
                pnt      <= set_ofs_i;
                cyc_cnt  <= '0;
                rep_cnt  <= '0;
                dly_cnt  <= '0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        pnt     <= set_ofs_i;
                        cyc_cnt <= '0;
                        rep_cnt <= '0;
                        if (trig) begin
                            state       <= ST_RUN;
                            trig_done_o <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (period_end) begin
                            pnt     <= set_wrap_i ? pnt_wrap[PW-1:0] : set_ofs_i;
                            cyc_cnt <= cyc_cnt + 16'd1;
                            if (last_period) begin
                                pnt     <= set_ofs_i;
                                cyc_cnt <= '0;
                                if (last_burst) begin
                                    state        <= ST_IDLE;
                                    rep_cnt      <= '0;
                                    burst_done_o <= 1'b1;
                                end else begin
                                    state    <= ST_DLY;
                                    rep_cnt  <= rep_cnt + 16'd1;
                                    dly_cnt  <= set_rdly_i;
                                    tick_cnt <= '0;
                                end
                            end
                        end else begin
                            pnt <= pnt_next[PW-1:0];
                        end
                    end
                    ST_DLY: begin
                        pnt <= set_ofs_i;
                        if (dly_cnt == 32'd0) begin
                            state   <= ST_RUN;
                            cyc_cnt <= '0;
                        end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
                            tick_cnt <= '0;
                            dly_cnt  <= dly_cnt - 32'd1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    logic [RSZ-1:0]         rd_addr;
    logic signed [DW-1:0]   smp_a, smp;
    logic signed [2*DW:0]   prod;
    logic signed [DW+1:0]   sum;

    assign rd_addr    = pnt[PW-1:FRW];
    assign buf_rpnt_o = rd_addr;

`ifdef ASG_CH_LINEAR_INTERP_EN
    logic [RSZ-1:0]            rd_addr_nx;
    logic signed [DW-1:0]      smp_b, smp_a2, smp_a3;
    logic [FRW-1:0]            frac1, frac2;
    logic signed [DW:0]        diff;
    logic signed [DW+FRW+1:0]  dmul;

    assign rd_addr_nx = rd_addr + 1'b1;

    // t[i] + (t[i+1]-t[i])*frac, the lower sample delayed to line up with the product
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            smp_a  <= '0;
            smp_b  <= '0;
            frac1  <= '0;
            diff   <= '0;
            smp_a2 <= '0;
            frac2  <= '0;
            dmul   <= '0;
            smp_a3 <= '0;
            smp    <= '0;
        end else begin
            smp_a  <= table_mem[rd_addr];
            smp_b  <= table_mem[rd_addr_nx];
            frac1  <= pnt[FRW-1:0];
            diff   <= {smp_b[DW-1], smp_b} - {smp_a[DW-1], smp_a};
            smp_a2 <= smp_a;
            frac2  <= frac1;
            dmul   <= diff * $signed({1'b0, frac2});
            smp_a3 <= smp_a2;
            smp    <= smp_a3 + dmul[DW+FRW-1:FRW];
        end
    end
`else
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            smp_a <= '0;
            smp   <= '0;
        end else begin
            smp_a <= table_mem[rd_addr];
            smp   <= smp_a;
        end
    end
`endif

    // sum keeps two guard bits so a full-scale product plus full-scale offset cannot wrap
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            prod  <= '0;
            sum   <= '0;
            dac_o <= '0;
        end else begin
            prod <= smp * $signed({1'b0, set_amp_i});
            sum  <= $signed(prod[2*DW:DW-1]) + $signed({{2{set_dc_i[DW-1]}}, set_dc_i});
            if (set_zero_i)
                dac_o <= '0;
            else if (sum[DW+1:DW-1] == 3'b000 || sum[DW+1:DW-1] == 3'b111)
                dac_o <= sum[DW-1:0];
            else if (sum[DW+1])
                dac_o <= {1'b1, {(DW-1){1'b0}}};
            else
                dac_o <= {1'b0, {(DW-1){1'b1}}};
        end
    end

endmodule
